// File: rtl/nway_cache.sv
// nway_cache: N-way set-associative, write-back, write-allocate data cache
// that sits between a 32-bit processor data port and a 128-bit line memory.
//
// Ports:
//   clk, proc_reset_n          clock (rising edge), async active-low reset
//   proc_read/proc_write       level requests, held until proc_stall=0
//   proc_addr[29:0]            word address {tag, set, word}
//   proc_wdata/proc_rdata      32-bit write / read data
//   proc_stall                 1 while the current request is not complete
//   mem_read/mem_write         line refill / write-back requests
//   mem_addr[27:0]             line address {tag, set}
//   mem_wdata/mem_rdata        128-bit line data, word0 in [31:0]
//   mem_ready                  one-cycle completion pulse from memory
//   cnt_clr                    synchronous clear of both performance counters
//   hit_count/miss_count       saturating performance counters
module nway_cache #(
    parameter int NUM_WAYS  = 4,
    parameter int SET_BITS  = 5,
    parameter int TAG_SIZE  = 28 - SET_BITS,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 proc_reset_n,
    input  logic                 proc_read,
    input  logic                 proc_write,
    input  logic [29:0]          proc_addr,
    input  logic [31:0]          proc_wdata,
    output logic [31:0]          proc_rdata,
    output logic                 proc_stall,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [27:0]          mem_addr,
    output logic [127:0]         mem_wdata,
    input  logic [127:0]         mem_rdata,
    input  logic                 mem_ready,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int NUM_SETS  = 1 << SET_BITS;
    localparam int WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LINE_BITS = WAY_BITS + SET_BITS;
    localparam logic [WAY_BITS-1:0] WAY_MASK = WAY_BITS'(NUM_WAYS - 1);

    typedef enum logic [1:0] {IDLE, COMP, WRITE, ALLOC} state_t;
    state_t state_reg, state_next;

    // Per-set state bits are resettable registers; tag and data are plain arrays.
    logic [NUM_WAYS-1:0] valid_reg  [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_reg  [NUM_SETS];
    logic [WAY_BITS-1:0] rr_ptr_reg [NUM_SETS];
    logic [TAG_SIZE-1:0] tag_mem    [1 << LINE_BITS];
    logic [127:0]        data_mem   [1 << LINE_BITS];

    logic [WAY_BITS-1:0]  victim_reg;
    logic                 victim_from_rr_reg;
    logic [CNT_WIDTH-1:0] hit_count_reg;
    logic [CNT_WIDTH-1:0] miss_count_reg;

    logic [SET_BITS-1:0]  set_idx;
    logic [TAG_SIZE-1:0]  tag_in;
    logic [1:0]           word_sel;
    logic                 req;
    logic [NUM_WAYS-1:0]  set_valid;
    logic [NUM_WAYS-1:0]  set_dirty;
    logic [NUM_WAYS-1:0]  hit_vec;
    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic                 any_invalid;
    logic [WAY_BITS-1:0]  inv_way;
    logic [WAY_BITS-1:0]  victim_sel;
    logic                 victim_wb;
    logic [LINE_BITS-1:0] hit_idx;
    logic [LINE_BITS-1:0] vic_idx;
    logic [127:0]         hit_line;
    logic                 comp_hit;
    logic                 comp_miss;

    assign set_idx   = proc_addr[SET_BITS+1:2];
    assign tag_in    = proc_addr[29:SET_BITS+2];
    assign word_sel  = proc_addr[1:0];
    assign req       = proc_read | proc_write;
    assign set_valid = valid_reg[set_idx];
    assign set_dirty = dirty_reg[set_idx];

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_tag_cmp
            assign hit_vec[gi] = set_valid[gi] &&
                                 (tag_mem[{WAY_BITS'(gi), set_idx}] == tag_in);
        end
    endgenerate

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        any_invalid = 1'b0;
        inv_way     = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!set_valid[w]) begin
                any_invalid = 1'b1;
                inv_way     = WAY_BITS'(w);
            end
        end
    end

    assign victim_sel = any_invalid ? inv_way : rr_ptr_reg[set_idx];
    assign victim_wb  = set_valid[victim_sel] & set_dirty[victim_sel];
    assign hit_idx    = {hit_way, set_idx};
    assign vic_idx    = {victim_reg, set_idx};
    assign hit_line   = data_mem[hit_idx];
    assign mem_wdata  = data_mem[vic_idx];
    assign comp_hit   = (state_reg == COMP) & req & hit;
    assign comp_miss  = (state_reg == COMP) & req & ~hit;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    always_comb begin
        state_next = state_reg;
        proc_stall = 1'b1;
        proc_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[29:2];
        case (state_reg)
            IDLE: state_next = COMP;
            COMP: begin
                proc_stall = req & ~hit;
                if (proc_read && hit)
                    proc_rdata = hit_line[32*word_sel +: 32];
                if (req && !hit)
                    state_next = victim_wb ? WRITE : ALLOC;
            end
            WRITE: begin
                mem_write = ~mem_ready;
                mem_addr  = {tag_mem[vic_idx], set_idx};
                if (mem_ready)
                    state_next = ALLOC;
            end
            ALLOC: begin
                mem_read = ~mem_ready;
                if (mem_ready)
                    state_next = COMP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_reg          <= IDLE;
            victim_reg         <= '0;
            victim_from_rr_reg <= 1'b0;
            hit_count_reg      <= '0;
            miss_count_reg     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_reg[s]  <= '0;
                dirty_reg[s]  <= '0;
                rr_ptr_reg[s] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (comp_miss) begin
                victim_reg         <= victim_sel;
                victim_from_rr_reg <= ~any_invalid;
            end
            if (comp_hit && proc_write)
                dirty_reg[set_idx][hit_way] <= 1'b1;
            if (state_reg == WRITE && mem_ready)
                dirty_reg[set_idx][victim_reg] <= 1'b0;
            if (state_reg == ALLOC && mem_ready) begin
                valid_reg[set_idx][victim_reg] <= 1'b1;
                dirty_reg[set_idx][victim_reg] <= 1'b0;
                // Only a round-robin pick consumes the pointer.
                if (victim_from_rr_reg)
                    rr_ptr_reg[set_idx] <= (rr_ptr_reg[set_idx] + 1'b1) & WAY_MASK;
            end
            if (cnt_clr)
                hit_count_reg <= '0;
            else if (comp_hit && hit_count_reg != '1)
                hit_count_reg <= hit_count_reg + 1'b1;
            if (cnt_clr)
                miss_count_reg <= '0;
            else if (comp_miss && miss_count_reg != '1)
                miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (comp_hit && proc_write)
            data_mem[hit_idx][32*word_sel +: 32] <= proc_wdata;
        if (state_reg == ALLOC && mem_ready) begin
            data_mem[vic_idx] <= mem_rdata;
            tag_mem[vic_idx]  <= tag_in;
        end
    end
endmodule

// File: tb/tb_nway_cache.sv
// tb_nway_cache: self-checking bench for nway_cache. A behavioural cache model
// (per-set way arrays, round-robin pointers, backing memory image) predicts
// read data, write-backs and counters; a memory responder with programmable
// latency serves the DUT. A second instance with CNT_WIDTH=4 shares all
// inputs and is used for counter saturation.
module tb_nway_cache;
    localparam int NW = 4;
    localparam int SB = 5;
    localparam int NS = 1 << SB;

    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b0;
    logic         proc_read = 1'b0, proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall, mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         cnt_clr = 1'b0;
    logic [31:0]  hit_count, miss_count;
    logic [31:0]  rdata4;
    logic         stall4, mrd4, mwr4;
    logic [27:0]  maddr4;
    logic [127:0] mwdata4;
    logic [3:0]   hit_count4, miss_count4;

    always #5 clk = ~clk;

    nway_cache dut (
        .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .hit_count(hit_count), .miss_count(miss_count));

    nway_cache #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rdata4),
        .proc_stall(stall4), .mem_read(mrd4), .mem_write(mwr4), .mem_addr(maddr4),
        .mem_wdata(mwdata4), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .hit_count(hit_count4), .miss_count(miss_count4));

    int total = 0;
    int bad = 0;

    // ---------------- memory images ----------------
    logic [127:0] mem_img [logic [27:0]];   // what the responder serves
    logic [127:0] ref_mem [logic [27:0]];   // what the model believes memory holds
    logic [155:0] wb_q [$];
    int mem_lat = 1;
    int resp_cnt = 0;

    function automatic logic [127:0] init_line(input logic [27:0] la);
        return {{4'hD, la}, {4'hC, la}, {4'hB, la}, {4'hA, la}};
    endfunction
    function automatic logic [127:0] img_get(input logic [27:0] la);
        if (mem_img.exists(la)) return mem_img[la];
        return init_line(la);
    endfunction
    function automatic logic [127:0] ref_get(input logic [27:0] la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return init_line(la);
    endfunction

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (!proc_reset_n || !(mem_read || mem_write)) begin
            resp_cnt = 0;
        end else begin
            resp_cnt++;
            if (resp_cnt > mem_lat) begin
                resp_cnt = 0;
                if (mem_write) begin
                    mem_img[mem_addr] = mem_wdata;
                    wb_q.push_back({mem_addr, mem_wdata});
                end else begin
                    mem_rdata = img_get(mem_addr);
                end
                mem_ready = 1'b1;
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit           m_valid [NS][NW];
    bit           m_dirty [NS][NW];
    logic [22:0]  m_tag   [NS][NW];
    logic [127:0] m_data  [NS][NW];
    int           m_rr    [NS];
    longint       m_hits = 0, m_miss = 0;

    logic [31:0]  exp_rd, obs_rd;
    bit           exp_miss, obs_to;
    int           exp_wbn, obs_wbn, obs_rdc;
    logic [27:0]  exp_wba, obs_wba, obs_rda;
    logic [127:0] exp_wbd, obs_wbd;

    task automatic model_reset;
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int k = 0; k < NW; k++) begin
                m_valid[s][k] = 1'b0;
                m_dirty[s][k] = 1'b0;
            end
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_access(input bit wr, input logic [29:0] a, input logic [31:0] d, input bit clr);
        int s, hw, v, w;
        bit from_rr;
        logic [22:0] t;
        logic [127:0] line;
        s = int'(a[SB+1:2]);
        t = a[29:SB+2];
        w = int'(a[1:0]);
        hw = -1;
        for (int k = 0; k < NW; k++)
            if (m_valid[s][k] && m_tag[s][k] == t) hw = k;
        exp_miss = (hw < 0);
        exp_wbn = 0;
        exp_wba = '0;
        exp_wbd = '0;
        if (hw < 0) begin
            v = -1;
            for (int k = 0; k < NW; k++)
                if (!m_valid[s][k] && v < 0) v = k;
            from_rr = (v < 0);
            if (from_rr) v = m_rr[s];
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wbn = 1;
                exp_wba = {m_tag[s][v], a[SB+1:2]};
                exp_wbd = m_data[s][v];
                ref_mem[exp_wba] = exp_wbd;
            end
            m_data[s][v]  = ref_get(a[29:2]);
            m_tag[s][v]   = t;
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            if (from_rr) m_rr[s] = (m_rr[s] + 1) % NW;
            m_miss++;
            hw = v;
        end
        line = m_data[s][hw];
        exp_rd = line[w*32 +: 32];
        if (wr) begin
            line[w*32 +: 32] = d;
            m_data[s][hw] = line;
            m_dirty[s][hw] = 1'b1;
        end
        m_hits++;
        if (clr) begin
            m_hits = 0;
            m_miss = 0;
        end
    endtask

    function automatic logic [29:0] mk_addr(input int tag, input int set, input int word);
        return {23'(tag), 5'(set), 2'(word)};
    endfunction

    // Runs one request through model and DUT and collects observations.
    task automatic run_access(input bit wr, input logic [29:0] a, input logic [31:0] d, input bit clr);
        int n;
        model_access(wr, a, d, clr);
        wb_q.delete();
        @(negedge clk);
        proc_read = !wr;
        proc_write = wr;
        proc_addr = a;
        proc_wdata = d;
        cnt_clr = clr;
        #1;
        obs_rdc = 0;
        obs_rda = '0;
        obs_to = 1'b0;
        n = 0;
        while (proc_stall) begin
            if (n >= 300) begin
                obs_to = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            n++;
            if (mem_read) begin
                if (obs_rdc == 0) obs_rda = mem_addr;
                obs_rdc++;
            end
        end
        obs_rd = proc_rdata;
        @(negedge clk);
        proc_read = 1'b0;
        proc_write = 1'b0;
        cnt_clr = 1'b0;
        obs_wbn = wb_q.size();
        obs_wba = '0;
        obs_wbd = '0;
        if (obs_wbn > 0) {obs_wba, obs_wbd} = wb_q[0];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        proc_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", proc_stall); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
        total++; if (proc_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", proc_rdata); end
        total++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        @(negedge clk);
        proc_reset_n = 1'b1;
        #1;
        total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL idle_stall got=%b exp=1", proc_stall); end
        @(negedge clk);
        #1;
        total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL comp_idle_stall got=%b exp=0", proc_stall); end
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL comp_idle_mem got=%b%b exp=00", mem_read, mem_write); end
        $display("reset: stall=%b hit=%0d miss=%0d", proc_stall, hit_count, miss_count);
    endtask

    task automatic test_cold_miss;
        logic [127:0] l;
        l = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        mem_img[28'h10] = l;
        ref_mem[28'h10] = l;
        mem_lat = 5;
        run_access(1'b0, 30'h0000_0041, 32'h0, 1'b0);
        total++; if (obs_to) begin bad++; $display("FAIL cold_timeout got=stalled exp=done"); end
        total++; if (obs_rdc !== 5) begin bad++; $display("FAIL cold_mem_read_cycles got=%0d exp=5", obs_rdc); end
        total++; if (obs_rda !== 28'h10) begin bad++; $display("FAIL cold_mem_addr got=%h exp=0000010", obs_rda); end
        total++; if (obs_rd !== 32'h2222_2222) begin bad++; $display("FAIL cold_rdata got=%h exp=22222222", obs_rd); end
        total++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin bad++; $display("FAIL cold_counters got=%0d/%0d exp=1/1", hit_count, miss_count); end
        $display("cold miss: rdata=%h rd_cycles=%0d addr=%h", obs_rd, obs_rdc, obs_rda);
        mem_lat = 1;
    endtask

    task automatic test_fill_evict;
        int tags [9] = '{1, 2, 3, 4, 5, 6, 3, 4, 1};
        int refills [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            run_access(1'b0, mk_addr(tags[i], 3, i % 4), 32'h0, 1'b0);
            total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL fill_rdata tag=%0d got=%h exp=%h", tags[i], obs_rd, exp_rd); end
            total++; if (obs_wbn !== 0) begin bad++; $display("FAIL fill_no_wb tag=%0d got=%0d exp=0", tags[i], obs_wbn); end
            total++; if (obs_rdc !== refills[i]) begin bad++; $display("FAIL fill_refill tag=%0d got=%0d exp=%0d", tags[i], obs_rdc, refills[i]); end
            $display("fill set3 tag=%0d rdata=%h refill=%0d wb=%0d", tags[i], obs_rd, obs_rdc, obs_wbn);
        end
        total++; if (miss_count !== 32'(m_miss)) begin bad++; $display("FAIL fill_miss_count got=%0d exp=%0d", miss_count, m_miss); end
    endtask

    task automatic test_dirty_evict;
        for (int t = 1; t <= 4; t++) run_access(1'b0, mk_addr(t, 7, 0), 32'h0, 1'b0);
        run_access(1'b1, mk_addr(1, 7, 2), 32'hDEAD_BEEF, 1'b0);
        run_access(1'b1, mk_addr(2, 7, 0), 32'h1234_5678, 1'b0);
        run_access(1'b0, mk_addr(5, 7, 1), 32'h0, 1'b0);
        total++; if (obs_wbn !== 1) begin bad++; $display("FAIL dirty_wb_count got=%0d exp=1", obs_wbn); end
        total++; if (obs_wba !== 28'h27) begin bad++; $display("FAIL dirty_wb_addr got=%h exp=0000027", obs_wba); end
        total++; if (obs_wbd[95:64] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dirty_wb_word got=%h exp=deadbeef", obs_wbd[95:64]); end
        total++; if (obs_wbd !== exp_wbd) begin bad++; $display("FAIL dirty_wb_line got=%h exp=%h", obs_wbd, exp_wbd); end
        $display("dirty evict: wb=%0d addr=%h data=%h", obs_wbn, obs_wba, obs_wbd);
        run_access(1'b0, mk_addr(6, 7, 0), 32'h0, 1'b0);
        total++; if (obs_wbn !== exp_wbn || obs_wba !== exp_wba) begin bad++; $display("FAIL dirty_second_wb got=%0d/%h exp=%0d/%h", obs_wbn, obs_wba, exp_wbn, exp_wba); end
        run_access(1'b0, mk_addr(1, 7, 2), 32'h0, 1'b0);
        total++; if (obs_rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dirty_reload got=%h exp=deadbeef", obs_rd); end
        $display("reload tag1 set7 word2 rdata=%h", obs_rd);
    endtask

    task automatic test_counters;
        run_access(1'b0, 30'h0000_0041, 32'h0, 1'b1);
        total++; if (obs_rdc !== 0) begin bad++; $display("FAIL clr_hit_refill got=%0d exp=0", obs_rdc); end
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL clr_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
        total++; if (hit_count4 !== 4'd0) begin bad++; $display("FAIL clr_counters4 got=%0d exp=0", hit_count4); end
        for (int i = 0; i < 20; i++) run_access(1'b0, mk_addr(0, 16, i % 4), 32'h0, 1'b0);
        total++; if (hit_count4 !== 4'd15) begin bad++; $display("FAIL sat_hit_count4 got=%0d exp=15", hit_count4); end
        total++; if (hit_count !== 32'(m_hits)) begin bad++; $display("FAIL hit_count20 got=%0d exp=%0d", hit_count, m_hits); end
        total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL miss_count_hits got=%0d exp=0", miss_count); end
        $display("counters: hit=%0d hit4=%0d miss=%0d", hit_count, hit_count4, miss_count);
    endtask

    task automatic test_random;
        bit wr;
        logic [29:0] a;
        logic [31:0] d;
        for (int i = 0; i < 250; i++) begin
            wr = 1'($urandom_range(0, 1));
            a = mk_addr($urandom_range(0, 5), 8 + $urandom_range(0, 3), $urandom_range(0, 3));
            d = $urandom;
            mem_lat = $urandom_range(0, 3);
            run_access(wr, a, d, 1'b0);
            total++; if (obs_to) begin bad++; $display("FAIL rand_timeout addr=%h got=stalled exp=done", a); end
            if (!wr) begin
                total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL rand_rdata addr=%h got=%h exp=%h", a, obs_rd, exp_rd); end
            end
            total++; if (obs_wbn !== exp_wbn) begin bad++; $display("FAIL rand_wb_count addr=%h got=%0d exp=%0d", a, obs_wbn, exp_wbn); end
            if (exp_wbn == 1) begin
                total++; if (obs_wba !== exp_wba || obs_wbd !== exp_wbd) begin bad++; $display("FAIL rand_wb addr=%h got=%h:%h exp=%h:%h", a, obs_wba, obs_wbd, exp_wba, exp_wbd); end
            end
            $display("rand %0d %s addr=%h wdata=%h rdata=%h miss=%0d wb=%0d", i, wr ? "W" : "R", a, d, obs_rd, exp_miss, obs_wbn);
        end
        total++; if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_miss)) begin bad++; $display("FAIL rand_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, m_hits, m_miss); end
        mem_lat = 1;
    endtask

    task automatic test_reset_alloc;
        logic [29:0] a;
        int n;
        a = mk_addr(9, 20, 1);
        mem_lat = 20;
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = a;
        #1;
        n = 0;
        while (!mem_read && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL ralloc_enter got=%b exp=1", mem_read); end
        proc_reset_n = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL ralloc_mem_read got=%b exp=0", mem_read); end
        total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL ralloc_stall got=%b exp=1", proc_stall); end
        proc_read = 1'b0;
        repeat (2) @(negedge clk);
        proc_reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        mem_lat = 2;
        run_access(1'b0, a, 32'h0, 1'b0);
        total++; if (obs_rdc !== 2) begin bad++; $display("FAIL ralloc_remiss got=%0d exp=2", obs_rdc); end
        total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL ralloc_rdata got=%h exp=%h", obs_rd, exp_rd); end
        total++; if (miss_count !== 32'd1 || hit_count !== 32'd1) begin bad++; $display("FAIL ralloc_counters got=%0d/%0d exp=1/1", hit_count, miss_count); end
        $display("reset in alloc: remiss refill=%0d rdata=%h", obs_rdc, obs_rd);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cold_miss();
        test_fill_evict();
        test_dirty_evict();
        test_counters();
        test_random();
        test_reset_alloc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
